// File: rtl/mmu_ctrl_pkg.sv
// Shared encodings for the MMU mapping controller: FSM states, register
// select codes and status-word layout.
package mmu_ctrl_pkg;

  localparam int unsigned PageNumWidthDefault = 20;

  typedef enum logic [1:0] {
    StKernel = 2'd0,
    StUser   = 2'd1,
    StFault  = 2'd2
  } state_e;

  localparam logic [1:0] WrSelVpage  = 2'd0;
  localparam logic [1:0] WrSelPpage  = 2'd1;
  localparam logic [1:0] WrSelMode   = 2'd2;
  localparam logic [1:0] WrSelClrCnt = 2'd3;

  localparam logic [1:0] RdSelVpage    = 2'd0;
  localparam logic [1:0] RdSelPpage    = 2'd1;
  localparam logic [1:0] RdSelBadvaddr = 2'd2;
  localparam logic [1:0] RdSelStatus   = 2'd3;

  localparam int unsigned StatusStateHi = 31;
  localparam int unsigned StatusStateLo = 30;

endpackage

// File: rtl/mmu_ctrl.sv
// Privileged mapping controller: stages the next user mapping, commits it on
// eret, and drops the MMU back to kernel mode on fault or trap entry.
module mmu_ctrl
  import mmu_ctrl_pkg::*;
#(
  parameter int unsigned PAGE_NUM_WIDTH = PageNumWidthDefault,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic                      stall,
  input  logic                      wr_en,
  input  logic [1:0]                wr_sel,
  input  logic [31:0]               wr_data,
  input  logic [1:0]                rd_sel,
  output logic [31:0]               rd_data,
  input  logic                      eret,
  input  logic                      trap_i,
  input  logic                      mmu_error_i,
  input  logic [31:0]               fault_vaddr_i,
  input  logic                      fault_ack,
  output logic                      fault_o,
  output logic                      mmu_en_o,
  output logic                      mmu_update_o,
  output logic [PAGE_NUM_WIDTH-1:0] vpage_o,
  output logic [PAGE_NUM_WIDTH-1:0] ppage_o
);

  state_e                    state_q, state_d;
  logic [PAGE_NUM_WIDTH-1:0] next_vpage_q, next_vpage_d;
  logic [PAGE_NUM_WIDTH-1:0] next_ppage_q, next_ppage_d;
  logic                      next_mode_q, next_mode_d;
  logic [31:0]               badvaddr_q, badvaddr_d;
  logic [CNT_WIDTH-1:0]      fault_cnt_q, fault_cnt_d;
  // Committed copies: what the MMU was last told with an update pulse.
  logic [PAGE_NUM_WIDTH-1:0] cur_vpage_q, cur_vpage_d;
  logic [PAGE_NUM_WIDTH-1:0] cur_ppage_q, cur_ppage_d;
  logic                      cur_en_q, cur_en_d;

  logic unused_wr_data;
  assign unused_wr_data = ^wr_data[31:PAGE_NUM_WIDTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q      <= StKernel;
      next_vpage_q <= '0;
      next_ppage_q <= '0;
      next_mode_q  <= 1'b0;
      badvaddr_q   <= '0;
      fault_cnt_q  <= '0;
      cur_vpage_q  <= '0;
      cur_ppage_q  <= '0;
      cur_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      next_vpage_q <= next_vpage_d;
      next_ppage_q <= next_ppage_d;
      next_mode_q  <= next_mode_d;
      badvaddr_q   <= badvaddr_d;
      fault_cnt_q  <= fault_cnt_d;
      cur_vpage_q  <= cur_vpage_d;
      cur_ppage_q  <= cur_ppage_d;
      cur_en_q     <= cur_en_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    next_vpage_d = next_vpage_q;
    next_ppage_d = next_ppage_q;
    next_mode_d  = next_mode_q;
    badvaddr_d   = badvaddr_q;
    fault_cnt_d  = fault_cnt_q;
    cur_vpage_d  = cur_vpage_q;
    cur_ppage_d  = cur_ppage_q;
    cur_en_d     = cur_en_q;
    mmu_update_o = 1'b0;

    if (!stall) begin
      unique case (state_q)
        StKernel: begin
          if (wr_en) begin
            case (wr_sel)
              WrSelVpage:  next_vpage_d = wr_data[PAGE_NUM_WIDTH-1:0];
              WrSelPpage:  next_ppage_d = wr_data[PAGE_NUM_WIDTH-1:0];
              WrSelMode:   next_mode_d  = wr_data[0];
              WrSelClrCnt: fault_cnt_d  = '0;
              default:     ;
            endcase
          end
          // Commit uses the pre-write staged values; a same-cycle write still lands.
          if (eret) begin
            mmu_update_o = 1'b1;
            cur_vpage_d  = next_vpage_q;
            cur_ppage_d  = next_ppage_q;
            cur_en_d     = next_mode_q;
            state_d      = next_mode_q ? StUser : StKernel;
          end
        end
        StUser: begin
          if (mmu_error_i) begin
            badvaddr_d = fault_vaddr_i;
            if (fault_cnt_q != {CNT_WIDTH{1'b1}}) begin
              fault_cnt_d = fault_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
            state_d = StFault;
          end else if (trap_i) begin
            mmu_update_o = 1'b1;
            cur_en_d     = 1'b0;
            state_d      = StKernel;
          end
        end
        StFault: begin
          if (fault_ack) begin
            mmu_update_o = 1'b1;
            cur_en_d     = 1'b0;
            state_d      = StKernel;
          end
        end
        default: state_d = StKernel;
      endcase
    end

    vpage_o  = cur_vpage_d;
    ppage_o  = cur_ppage_d;
    mmu_en_o = cur_en_d;

    // Reset forces the MMU off regardless of state.
    if (clr) begin
      mmu_update_o = 1'b1;
      mmu_en_o     = 1'b0;
      vpage_o      = '0;
      ppage_o      = '0;
    end
  end

  assign fault_o = (state_q == StFault) && !clr;

  always_comb begin
    rd_data = '0;
    case (rd_sel)
      RdSelVpage:    rd_data = 32'(next_vpage_q);
      RdSelPpage:    rd_data = 32'(next_ppage_q);
      RdSelBadvaddr: rd_data = badvaddr_q;
      RdSelStatus: begin
        rd_data[CNT_WIDTH-1:0]             = fault_cnt_q;
        rd_data[StatusStateHi:StatusStateLo] = state_q;
      end
      default:       rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_mmu_ctrl.sv
// Self-checking bench for mmu_ctrl: directed scenarios plus randomized
// traffic against a behavioural mapping-controller model.
module tb_mmu_ctrl;

  logic        clk = 1'b0;
  logic        clr, stall, wr_en, eret, trap_i, mmu_error_i, fault_ack;
  logic [1:0]  wr_sel, rd_sel;
  logic [31:0] wr_data, fault_vaddr_i, rd_data;
  logic        fault_o, mmu_en_o, mmu_update_o;
  logic [19:0] vpage_o, ppage_o;

  int checks = 0;
  int failures = 0;

  mmu_ctrl #(.PAGE_NUM_WIDTH(20), .CNT_WIDTH(16)) dut (
    .clk          (clk),
    .clr          (clr),
    .stall        (stall),
    .wr_en        (wr_en),
    .wr_sel       (wr_sel),
    .wr_data      (wr_data),
    .rd_sel       (rd_sel),
    .rd_data      (rd_data),
    .eret         (eret),
    .trap_i       (trap_i),
    .mmu_error_i  (mmu_error_i),
    .fault_vaddr_i(fault_vaddr_i),
    .fault_ack    (fault_ack),
    .fault_o      (fault_o),
    .mmu_en_o     (mmu_en_o),
    .mmu_update_o (mmu_update_o),
    .vpage_o      (vpage_o),
    .ppage_o      (ppage_o)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 kernel, 1 user, 2 fault.
  int          m_mode, n_mode;
  logic [19:0] m_nv, m_np, m_cv, m_cp, n_nv, n_np, n_cv, n_cp;
  logic        m_nm, m_ce, n_nm, n_ce;
  logic [31:0] m_bad, n_bad;
  int unsigned m_cnt, n_cnt;
  logic        e_upd, e_en, e_fault;
  logic [19:0] e_vp, e_pp;
  logic [31:0] e_rd;

  task automatic model_eval();
    n_mode = m_mode; n_nv = m_nv; n_np = m_np; n_nm = m_nm;
    n_bad = m_bad; n_cnt = m_cnt; n_cv = m_cv; n_cp = m_cp; n_ce = m_ce;
    e_upd = 1'b0; e_vp = m_cv; e_pp = m_cp; e_en = m_ce;
    e_fault = (m_mode == 2);
    case (rd_sel)
      2'd0: e_rd = {12'h0, m_nv};
      2'd1: e_rd = {12'h0, m_np};
      2'd2: e_rd = m_bad;
      default: e_rd = (32'(m_mode) << 30) | m_cnt;
    endcase
    if (clr) begin
      e_upd = 1'b1; e_en = 1'b0; e_vp = '0; e_pp = '0; e_fault = 1'b0;
      n_mode = 0; n_nv = '0; n_np = '0; n_nm = 1'b0; n_bad = '0;
      n_cnt = 0; n_cv = '0; n_cp = '0; n_ce = 1'b0;
    end else if (!stall) begin
      if (m_mode == 0) begin
        if (wr_en && wr_sel == 2'd0) n_nv = wr_data[19:0];
        if (wr_en && wr_sel == 2'd1) n_np = wr_data[19:0];
        if (wr_en && wr_sel == 2'd2) n_nm = wr_data[0];
        if (wr_en && wr_sel == 2'd3) n_cnt = 0;
        if (eret) begin
          e_upd = 1'b1; e_vp = m_nv; e_pp = m_np; e_en = m_nm;
          n_cv = m_nv; n_cp = m_np; n_ce = m_nm;
          n_mode = m_nm ? 1 : 0;
        end
      end else if (m_mode == 1) begin
        if (mmu_error_i) begin
          n_bad = fault_vaddr_i;
          n_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
          n_mode = 2;
        end else if (trap_i) begin
          e_upd = 1'b1; e_en = 1'b0; n_ce = 1'b0; n_mode = 0;
        end
      end else if (fault_ack) begin
        e_upd = 1'b1; e_en = 1'b0; n_ce = 1'b0; n_mode = 0;
      end
    end
  endtask

  task automatic model_commit();
    m_mode = n_mode; m_nv = n_nv; m_np = n_np; m_nm = n_nm;
    m_bad = n_bad; m_cnt = n_cnt; m_cv = n_cv; m_cp = n_cp; m_ce = n_ce;
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic idle_inputs();
    clr = 0; stall = 0; wr_en = 0; wr_sel = 0; wr_data = 0; rd_sel = 0;
    eret = 0; trap_i = 0; mmu_error_i = 0; fault_vaddr_i = 0; fault_ack = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    clr = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (mmu_update_o !== 1'b1 || mmu_en_o !== 1'b0 || vpage_o !== 20'h0 ||
          ppage_o !== 20'h0 || fault_o !== 1'b0) begin
        failures++;
        $display("FAIL reset_force upd=%b en=%b vp=%h pp=%h fault=%b want 1 0 0 0 0",
                 mmu_update_o, mmu_en_o, vpage_o, ppage_o, fault_o);
      end
      tick();
    end
    clr = 0;
    for (int s = 0; s < 4; s++) begin
      rd_sel = 2'(s);
      #1;
      checks++;
      if (rd_data !== 32'h0) begin
        failures++;
        $display("FAIL reset_rd sel=%0d got=%h want=0", s, rd_data);
      end
    end
    checks++;
    if (mmu_update_o !== 1'b0 || fault_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle upd=%b fault=%b want 0 0", mmu_update_o, fault_o);
    end
    tick();
  endtask

  task automatic test_commit();
    idle_inputs();
    wr_en = 1; wr_sel = 0; wr_data = 32'h0000_0400; tick();
    wr_sel = 1; wr_data = 32'hFFF0_1234; tick();
    wr_sel = 2; wr_data = 32'h1; tick();
    wr_en = 0; eret = 1;
    #1;
    checks++;
    if (mmu_update_o !== 1'b1 || vpage_o !== 20'h00400 || ppage_o !== 20'h01234 ||
        mmu_en_o !== 1'b1) begin
      failures++;
      $display("FAIL commit upd=%b vp=%h pp=%h en=%b want 1 00400 01234 1",
               mmu_update_o, vpage_o, ppage_o, mmu_en_o);
    end
    tick();
    eret = 0; rd_sel = 3;
    #1;
    checks++;
    if (rd_data !== 32'h4000_0000 || mmu_update_o !== 1'b0 || mmu_en_o !== 1'b1) begin
      failures++;
      $display("FAIL commit_status rd=%h upd=%b en=%b want 40000000 0 1",
               rd_data, mmu_update_o, mmu_en_o);
    end
  endtask

  task automatic test_fault();
    idle_inputs();
    mmu_error_i = 1; fault_vaddr_i = 32'h0050_0ABC;
    #1;
    checks++;
    if (fault_o !== 1'b0) begin
      failures++;
      $display("FAIL fault_early got=%b want=0", fault_o);
    end
    tick();
    mmu_error_i = 0; fault_vaddr_i = 0; rd_sel = 2;
    #1;
    checks++;
    if (fault_o !== 1'b1 || rd_data !== 32'h0050_0ABC) begin
      failures++;
      $display("FAIL fault_capture fault=%b bad=%h want 1 00500abc", fault_o, rd_data);
    end
    rd_sel = 3;
    #1;
    checks++;
    if (rd_data !== 32'h8000_0001) begin
      failures++;
      $display("FAIL fault_status got=%h want=80000001", rd_data);
    end
    eret = 1; trap_i = 1; mmu_error_i = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (mmu_update_o !== 1'b0 || fault_o !== 1'b1) begin
        failures++;
        $display("FAIL fault_hold cyc=%0d upd=%b fault=%b want 0 1", i, mmu_update_o, fault_o);
      end
      tick();
    end
    eret = 0; trap_i = 0; mmu_error_i = 0; fault_ack = 1;
    #1;
    checks++;
    if (mmu_update_o !== 1'b1 || mmu_en_o !== 1'b0 || fault_o !== 1'b1 ||
        vpage_o !== 20'h00400 || ppage_o !== 20'h01234) begin
      failures++;
      $display("FAIL fault_ack upd=%b en=%b fault=%b vp=%h pp=%h want 1 0 1 00400 01234",
               mmu_update_o, mmu_en_o, fault_o, vpage_o, ppage_o);
    end
    tick();
    fault_ack = 0;
    #1;
    checks++;
    if (fault_o !== 1'b0 || rd_data !== 32'h0000_0001) begin
      failures++;
      $display("FAIL fault_exit fault=%b status=%h want 0 00000001", fault_o, rd_data);
    end
  endtask

  task automatic test_stall_trap();
    idle_inputs();
    eret = 1; tick();
    eret = 0; trap_i = 1; stall = 1; rd_sel = 3;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (mmu_update_o !== 1'b0 || rd_data[31:30] !== 2'd1) begin
        failures++;
        $display("FAIL stall_trap cyc=%0d upd=%b state=%0d want 0 1",
                 i, mmu_update_o, rd_data[31:30]);
      end
      tick();
    end
    stall = 0;
    #1;
    checks++;
    if (mmu_update_o !== 1'b1 || mmu_en_o !== 1'b0 || vpage_o !== 20'h00400) begin
      failures++;
      $display("FAIL trap_update upd=%b en=%b vp=%h want 1 0 00400",
               mmu_update_o, mmu_en_o, vpage_o);
    end
    tick();
    trap_i = 0;
    #1;
    checks++;
    if (rd_data[31:30] !== 2'd0 || mmu_en_o !== 1'b0) begin
      failures++;
      $display("FAIL trap_kernel state=%0d en=%b want 0 0", rd_data[31:30], mmu_en_o);
    end
  endtask

  task automatic test_priv_write();
    idle_inputs();
    eret = 1; tick();
    eret = 0; wr_en = 1; wr_sel = 0; wr_data = 32'h55; tick();
    wr_en = 0; trap_i = 1; tick();
    trap_i = 0; rd_sel = 0;
    #1;
    checks++;
    if (rd_data !== 32'h400) begin
      failures++;
      $display("FAIL user_write_ignored got=%h want=00000400", rd_data);
    end
    wr_en = 1; wr_sel = 0; wr_data = 32'h7; eret = 1;
    #1;
    checks++;
    if (mmu_update_o !== 1'b1 || vpage_o !== 20'h00400) begin
      failures++;
      $display("FAIL eret_old_vpage upd=%b vp=%h want 1 00400", mmu_update_o, vpage_o);
    end
    tick();
    wr_en = 0; eret = 0;
    #1;
    checks++;
    if (rd_data !== 32'h7 || vpage_o !== 20'h00400) begin
      failures++;
      $display("FAIL write_landed rd=%h vp=%h want 00000007 00400", rd_data, vpage_o);
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 600; cyc++) begin
      clr           = ($urandom_range(0, 99) < 2);
      stall         = clr ? 1'b0 : ($urandom_range(0, 3) == 0);
      wr_en         = ($urandom_range(0, 9) < 4);
      wr_sel        = 2'($urandom_range(0, 3));
      wr_data       = $urandom;
      if ($urandom_range(0, 1) == 1) wr_data[0] = 1'b1;
      rd_sel        = 2'($urandom_range(0, 3));
      eret          = ($urandom_range(0, 9) < 3);
      trap_i        = ($urandom_range(0, 9) < 2);
      mmu_error_i   = ($urandom_range(0, 9) < 2);
      fault_vaddr_i = $urandom;
      fault_ack     = ($urandom_range(0, 9) < 3);
      #1;
      model_eval();
      checks++;
      if (mmu_update_o !== e_upd || mmu_en_o !== e_en || vpage_o !== e_vp ||
          ppage_o !== e_pp || fault_o !== e_fault || rd_data !== e_rd) begin
        failures++;
        $display("FAIL rnd cyc=%0d got upd=%b en=%b vp=%h pp=%h f=%b rd=%h want %b %b %h %h %b %h",
                 cyc, mmu_update_o, mmu_en_o, vpage_o, ppage_o, fault_o, rd_data,
                 e_upd, e_en, e_vp, e_pp, e_fault, e_rd);
      end
      tick();
    end
  endtask

  initial begin
    m_mode = 0; m_nv = '0; m_np = '0; m_nm = 1'b0; m_bad = '0; m_cnt = 0;
    m_cv = '0; m_cp = '0; m_ce = 1'b0;
    test_reset();
    test_commit();
    test_fault();
    test_stall_trap();
    test_priv_write();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmu_ctrl.md
Name: mmu_ctrl

Overview:
Privileged mapping controller that drives the single-page MMU's update interface: vpage, ppage, mmu_en and mmu_update.
- Kernel software stages the next user mapping with register writes.
- A valid eret commits the staged mapping to the MMU.
- The block receives the MMU's error output, captures the faulting virtual address, raises a fault request to the CU, and switches the MMU back to kernel (untranslated) mode on fault or trap entry.
- Sits beside the CU, between the pipeline control and the MMU.

Parameters:
PAGE_NUM_WIDTH, 20, page-number width; must match the MMU (20 = 4 KB pages).
CNT_WIDTH, 16, width of the saturating fault counter.

Ports:
clk  in  1  clock.
clr  in  1  synchronous active-high reset.
stall  in  1  pipeline stall; freezes all state updates and update pulses.
wr_en  in  1  privileged register write strobe.
wr_sel  in  2  write target: 0 next_vpage, 1 next_ppage, 2 next_mode (bit0 = user), 3 clear fault counter.
wr_data  in  32  write data; page fields take bits [PAGE_NUM_WIDTH-1:0].
rd_sel  in  2  read select: 0 next_vpage, 1 next_ppage, 2 badvaddr, 3 {status, fault_cnt}.
rd_data  out  32  combinational read data, zero-extended.
eret  in  1  valid eret in the commit stage.
trap_i  in  1  non-MMU exception or interrupt entry.
mmu_error_i  in  1  MMU page-mismatch error.
fault_vaddr_i  in  32  virtual address presented to the MMU.
fault_ack  in  1  CU accepted the fault and is redirecting to the handler.
fault_o  out  1  MMU fault request to the CU.
mmu_en_o  out  1  to MMU mmu_en.
mmu_update_o  out  1  to MMU mmu_update; single-cycle pulse.
vpage_o  out  PAGE_NUM_WIDTH  to MMU vpage_in.
ppage_o  out  PAGE_NUM_WIDTH  to MMU ppage_in.

Behaviour:
- Clocking and reset:
  - One clock (clk); reset clr is synchronous, active-high.
  - Reset clears all registers and sets the FSM to KERNEL. fault_o=0, rd_data reflects zeroed registers.
  - While clr=1: mmu_update_o=1, mmu_en_o=0, vpage_o=ppage_o=0, so the MMU is forced off. The CU must hold stall=0 during reset.
- Registers: next_vpage, next_ppage, next_mode, badvaddr[31:0], fault_cnt (saturating), and the FSM state.
- FSM states KERNEL, USER, FAULT. No transition occurs while stall=1.
- KERNEL:
  - wr_en writes the selected register at the clock edge.
  - eret: mmu_update_o=1 in the same cycle, driving vpage_o=next_vpage, ppage_o=next_ppage, mmu_en_o=next_mode. Next state is USER if next_mode=1, else KERNEL.
  - wr_en and eret in the same cycle: eret commits the pre-write values; the write still lands.
  - mmu_error_i and trap_i are ignored.
- USER:
  - wr_en is ignored (privileged).
  - mmu_error_i=1: badvaddr<=fault_vaddr_i, fault_cnt increments (holds at all-ones), next state FAULT.
  - trap_i=1 with no error: mmu_update_o=1 and mmu_en_o=0 in the same cycle, with vpage/ppage held at the committed values. Next state KERNEL.
  - mmu_error_i has priority over trap_i. eret in USER is ignored.
- FAULT:
  - fault_o=1, registered, from the cycle after error capture.
  - While fault_ack=0: hold; ignore eret, trap_i, wr_en and further errors.
  - fault_ack=1: fault_o still high this cycle; mmu_update_o=1, mmu_en_o=0. Next state KERNEL; fault_o=0 in the following cycle.
- Outputs when no update is pulsing:
  - vpage_o, ppage_o and mmu_en_o show the committed copies: the last values presented with an update pulse.
  - mmu_update_o=0 whenever stall=1, except during clr.
- Status field, rd_sel=3: bits[31:30] = state (KERNEL=0, USER=1, FAULT=2), bits[CNT_WIDTH-1:0] = fault_cnt.
- wr_sel=3 clears fault_cnt in KERNEL only.
- Latency:
  - Error to fault_o: 1 cycle.
  - eret, trap_i and fault_ack to mmu_update_o: 0 cycles (combinational).

Decomposition:
- Shared package: state encodings, wr_sel/rd_sel codes, status bit positions.
- The PAGE_NUM_WIDTH default is shared with the MMU.
- No sub-module is needed; the fault counter can be an inline saturating counter.

Test Plan:
1. Reset with clr=1 for 2 cycles → mmu_update_o=1, mmu_en_o=0 and pages 0 while clr is high; afterwards state KERNEL, rd_data=0 for all selects.
2. Write vpage=0x00400, ppage=0x01234, mode=1, then eret → same-cycle mmu_update_o=1, vpage_o=0x00400, ppage_o=0x01234, mmu_en_o=1; status reads USER.
3. In USER, mmu_error_i=1 with fault_vaddr_i=0x00500ABC → next cycle fault_o=1, badvaddr=0x00500ABC, fault_cnt=1.
4. Continuing from 3, hold fault_ack=0 for 5 cycles with eret=1 → no update; then fault_ack=1 → mmu_update_o=1, mmu_en_o=0; state KERNEL; fault_o=0 next cycle.
5. In USER, trap_i=1 with stall=1 for 3 cycles → no update and state stays USER; stall drops → immediate update with mmu_en_o=0, state KERNEL.
6. In USER, wr_en to vpage → ignored. In KERNEL, wr_en vpage=0x7 together with eret → commits the old vpage, and a later read returns 0x7.
